// File: rtl/bank_pkg.sv
// Shared definitions for the color register bank access controller:
// default geometry, sequencer state encoding and the color step function.
package bank_pkg;

  localparam int unsigned BANK_ADDR_W = 4;
  localparam int unsigned BANK_DATA_W = 3;

  // Update sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    CLR  = 2'd3
  } seq_state_e;

  // Next color code: increment modulo 2^width, so the top code wraps to 0.
  function automatic logic [31:0] color_inc(input logic [31:0] color,
                                            input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (color + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level input
// is seen high. Shared by keypad-driven blocks.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Remember the previous level of the input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/bank_access_ctrl.sv
// Time-slot owner of the single-port color register bank. Even slots (ph=0)
// serve the VGA renderer, odd slots (ph=1) serve the update sequencer, which
// performs keypad read-modify-write increments and full-bank clears.
// The bank itself is external; this block holds no storage array.
module bank_access_ctrl
  import bank_pkg::*;
#(
  parameter int unsigned ADDR_W     = BANK_ADDR_W,
  parameter int unsigned DATA_W     = BANK_DATA_W,
  parameter bit          CLR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_opr,
  input  logic [ADDR_W-1:0] key_pos,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              wr_done
);

  logic              ph_q;
  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rmw_q, rmw_d;
  logic              pend_key_q, pend_key_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_clr_q, pend_clr_d;
  logic [DATA_W-1:0] vga_data_q;
  logic              vga_valid_q;

  logic              key_rise;
  logic              key_done;
  logic              clr_done;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_we;
  logic [DATA_W-1:0] seq_wdata;

  edge_rise u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .sig_i (key_opr),
    .rise_o(key_rise)
  );

  // Pending request bookkeeping: one held key, clear requests merge.
  always_comb begin
    pend_key_d  = pend_key_q;
    pend_addr_d = pend_addr_q;
    pend_clr_d  = pend_clr_q;
    if (key_done) begin
      pend_key_d = 1'b0;
    end else if (key_rise && !pend_key_q) begin
      pend_key_d  = 1'b1;
      pend_addr_d = key_pos;
    end
    if (clr_req) begin
      pend_clr_d = 1'b1;
    end else if (clr_done) begin
      pend_clr_d = 1'b0;
    end
  end

  // Sequencer next state and its bank access; decisions only in odd slots.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case/if tree leaves it unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rmw_d     = rmw_q;
    key_done  = 1'b0;
    clr_done  = 1'b0;
    seq_addr  = '0;
    seq_we    = 1'b0;
    seq_wdata = '0;
    if (!ph_q) begin
      // Read data issued in the RD slot is on mem_rdata during this VGA slot.
      if (state_q == WR) begin
        rmw_d = mem_rdata;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_clr_q) begin
            state_d = CLR;
            cnt_d   = '0;
          end else if (pend_key_q) begin
            state_d = RD;
          end
        end
        RD: begin
          seq_addr = pend_addr_q;
          state_d  = WR;
        end
        WR: begin
          seq_addr  = pend_addr_q;
          seq_we    = 1'b1;
          seq_wdata = DATA_W'(color_inc(32'(rmw_q), DATA_W));
          key_done  = 1'b1;
          state_d   = IDLE;
        end
        CLR: begin
          seq_addr = cnt_q;
          seq_we   = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            clr_done = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Slot toggle, sequencer state and pending requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q        <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rmw_q       <= '0;
      pend_key_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_clr_q  <= CLR_ON_RST;
    end else begin
      ph_q        <= ~ph_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rmw_q       <= rmw_d;
      pend_key_q  <= pend_key_d;
      pend_addr_q <= pend_addr_d;
      pend_clr_q  <= pend_clr_d;
    end
  end

  // Renderer result register: capture read data one slot after the VGA read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_data_q  <= '0;
      vga_valid_q <= 1'b0;
    end else begin
      vga_valid_q <= ph_q;
      if (ph_q) begin
        vga_data_q <= mem_rdata;
      end
    end
  end

  // The VGA address passes straight through in even slots; hold the bus at
  // address 0 while in reset so the bank sees a quiet interface.
  assign mem_addr  = !rst ? '0 : (ph_q ? seq_addr : vga_addr);
  assign mem_we    = seq_we;
  assign mem_wdata = seq_wdata;
  assign wr_done   = key_done;
  assign busy      = (state_q != IDLE) | pend_key_q | pend_clr_q;
  assign vga_data  = vga_data_q;
  assign vga_valid = vga_valid_q;

endmodule

// File: tb/tb_bank_access_ctrl.sv
// Self-checking bench for bank_access_ctrl. The bench owns a behavioural
// model of the external bank and a high-level model of expected contents
// (clear -> all zero, key press -> cell + 1 mod 8).
module tb_bank_access_ctrl;

  logic       clk;
  logic       rst;
  logic       key_opr;
  logic [3:0] key_pos;
  logic       clr_req;
  logic [3:0] vga_addr;
  logic [2:0] vga_data;
  logic       vga_valid;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata;
  logic       busy;
  logic       wr_done;

  bank_access_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .key_opr  (key_opr),
    .key_pos  (key_pos),
    .clr_req  (clr_req),
    .vga_addr (vga_addr),
    .vga_data (vga_data),
    .vga_valid(vga_valid),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .wr_done  (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External bank: synchronous read, 1-cycle latency; pokes preload cells.
  logic [2:0] bank [16];
  logic       poke_en;
  logic [3:0] poke_addr;
  logic [2:0] poke_val;

  always @(posedge clk) begin
    if (mem_we) bank[mem_addr] <= mem_wdata;
    else if (poke_en) bank[poke_addr] <= poke_val;
    mem_rdata <= bank[mem_addr];
  end

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         wr_events = 0;
  int         last_done_cyc = 0;
  bit         sweep = 1'b0;
  logic       ph_ref = 1'b0;
  logic       s1_valid = 1'b0;
  logic [2:0] s1_data = '0;
  logic       exp_valid = 1'b0;
  logic [2:0] exp_vdata = '0;
  logic [2:0] exp_bank [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance slot/VGA model at the edge, check outputs 1ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (mem_we) wr_events++;
      exp_valid = s1_valid;
      if (s1_valid) exp_vdata = s1_data;
      s1_valid = (ph_ref == 1'b0);
      s1_data  = bank[vga_addr];
      ph_ref   = ~ph_ref;
    end else begin
      exp_valid = 1'b0;
      exp_vdata = '0;
      s1_valid  = 1'b0;
      ph_ref    = 1'b0;
    end
    cyc++;
    #1;
    check("vga_valid", vga_valid, exp_valid);
    check("vga_data", vga_data, exp_vdata);
    if (mem_we) check("we_in_vga_slot", ph_ref, 1);
    if (wr_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (sweep) vga_addr = vga_addr + 4'd1;
  endtask

  task automatic poke(input int a, input logic [2:0] v);
    poke_addr = 4'(a);
    poke_val  = v;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
    exp_bank[a] = v;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_cell%0d", tag, i), bank[i], exp_bank[i]);
  endtask

  // Read one cell through the renderer port, aligned to a VGA slot.
  task automatic read_vga(input int a);
    bit saved = sweep;
    sweep = 1'b0;
    vga_addr = 4'(a);
    if (ph_ref) tick();
    tick();
    tick();
    check($sformatf("vga_rd%0d", a), vga_data, exp_bank[a]);
    sweep = saved;
  endtask

  task automatic model_key(input int pos);
    exp_bank[pos] = 3'((int'(exp_bank[pos]) + 1) % 8);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_bank[i] = '0;
  endtask

  task automatic do_key(input int pos, input int hold);
    key_pos = 4'(pos);
    key_opr = 1'b1;
    repeat (hold) tick();
    key_opr = 1'b0;
    tick();
    wait_idle(100);
    model_key(pos);
  endtask

  task automatic do_clear();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_idle(100);
    model_clear();
  endtask

  initial begin
    int t0, d0, w0, p0, old4;
    rst = 1'b0;
    key_opr = 1'b0;
    key_pos = '0;
    clr_req = 1'b0;
    vga_addr = '0;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_val = '0;
    for (int i = 0; i < 16; i++) exp_bank[i] = '0;

    // Reset state.
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_vga_valid", vga_valid, 0);
    check("rst_vga_data", vga_data, 0);

    // Preload 5s, then release: the auto-clear sweep zeroes the bank.
    for (int i = 0; i < 16; i++) poke(i, 3'd5);
    check("preload", bank[11], 5);
    rst = 1'b1;
    model_clear();
    t0 = cyc;
    wait_idle(60);
    check("autoclr_time", ((cyc - t0) >= 32 && (cyc - t0) <= 36), 1);
    check_bank("autoclr");
    for (int i = 0; i < 16; i++) read_vga(i);

    // Cell 7 = 3, key held 100 cycles: exactly one write, cell becomes 4.
    sweep = 1'b1;
    poke(7, 3'd3);
    d0 = done_cnt;
    w0 = wr_events;
    key_pos = 4'd7;
    key_opr = 1'b1;
    p0 = cyc;
    repeat (100) tick();
    key_opr = 1'b0;
    tick();
    model_key(7);
    check("hold_one_done", done_cnt - d0, 1);
    check("hold_one_write", wr_events - w0, 1);
    check("key_latency", (last_done_cyc - p0) <= 6, 1);
    check("cell7", bank[7], 4);
    read_vga(7);

    // Cell 2 = 7 wraps to 0.
    poke(2, 3'd7);
    do_key(2, 3);
    check("cell2_wrap", bank[2], 0);
    read_vga(2);

    // Key 9 pressed during a clear sweep: applied after the clear.
    for (int i = 0; i < 16; i++) poke(i, 3'(i));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (6) tick();
    check("clr_running", busy, 1);
    key_pos = 4'd9;
    key_opr = 1'b1;
    repeat (2) tick();
    key_opr = 1'b0;
    tick();
    wait_idle(100);
    model_clear();
    model_key(9);
    check_bank("clr_key9");

    // Randomized key presses and clears against the contents model.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) do_clear();
      else do_key(int'($urandom_range(0, 15)), int'($urandom_range(1, 20)));
      check_bank($sformatf("rnd%0d", it));
    end

    // Reset asserted during the WR slot: no write, outputs at reset values.
    poke(4, 3'd2);
    key_pos = 4'd4;
    key_opr = 1'b1;
    for (int n = 0; n < 20 && wr_done !== 1'b1; n++) tick();
    check("wr_slot_found", wr_done, 1);
    old4 = int'(bank[4]);
    w0 = wr_events;
    rst = 1'b0;
    key_opr = 1'b0;
    #1;
    check("rstwr_mem_we", mem_we, 0);
    check("rstwr_wr_done", wr_done, 0);
    check("rstwr_mem_addr", mem_addr, 0);
    check("rstwr_mem_wdata", mem_wdata, 0);
    check("rstwr_vga_valid", vga_valid, 0);
    check("rstwr_vga_data", vga_data, 0);
    tick();
    check("rstwr_no_write", bank[4], old4);
    check("rstwr_no_event", wr_events - w0, 0);
    tick();
    rst = 1'b1;
    model_clear();
    wait_idle(60);
    check_bank("post_rst");
    read_vga(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
